// File: rtl/alu_arb_pkg.sv
// Shared constants for the ALU arbiter: ALU op encodings, idle control word
// and the arbiter state encoding.
package alu_arb_pkg;

  localparam logic [1:0] OP_AND       = 2'b00;
  localparam logic [1:0] OP_OR        = 2'b01;
  localparam logic [1:0] OP_ADD_SUB   = 2'b10;
  localparam logic [1:0] OP_NOP       = 2'b11;
  localparam int         CTRL_SUB_BIT = 2;

  // Control word driven onto the ALU when nobody holds a grant.
  localparam logic [3:0] ALU_CTRL_IDLE = {2'b00, OP_NOP};

  localparam logic [0:0] ARB  = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating priority encoder: picks the first set request
// at or above ptr, wrapping around to index 0.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic [IDW-1:0]   gnt_id,
  output logic             any
);

  // Walk the requesters in rotated order and keep the first hit.
  always_comb begin
    int idx;
    gnt_onehot = '0;
    gnt_id     = '0;
    any        = 1'b0;
    idx        = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_onehot[idx] = 1'b1;
        gnt_id          = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of a single 8-bit ALU. Grants one requester
// per cycle, supports a lock for chained ops with an idle timeout, and
// returns the ALU result tagged with the issuing requester one cycle later.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int IDW      = 2,
  parameter int LOCK_MAX = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ-1:0]   req_lock,
  input  logic [N_REQ*8-1:0] req_a,
  input  logic [N_REQ*8-1:0] req_b,
  input  logic [N_REQ*4-1:0] req_ctrl,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [7:0]         rsp_result,
  output logic               rsp_zero,
  output logic               rsp_overflow,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  output logic [3:0]         alu_control,
  input  logic [7:0]         alu_result,
  input  logic               alu_zero,
  input  logic               alu_overflow
);

  logic [0:0]       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [7:0]       idle_cnt_q, idle_cnt_d;
  logic             inflight_v_q, inflight_v_d;
  logic [IDW-1:0]   inflight_id_q, inflight_id_d;

  logic [N_REQ-1:0] owner_mask;
  logic [N_REQ-1:0] pick_req;
  logic [N_REQ-1:0] pick_onehot;
  logic [IDW-1:0]   gnt_id;
  logic             pick_any;
  logic [N_REQ-1:0] gnt;
  logic             issue;
  logic             lock_sel;
  logic [7:0]       idle_inc;

  // Successor of a requester ID, wrapping at N_REQ.
  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    if (int'(id) >= N_REQ - 1) return '0;
    return id + IDW'(1);
  endfunction

  // One-hot masks for the lock owner and the in-flight response target.
  always_comb begin
    owner_mask = '0;
    rsp_valid  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      owner_mask[i] = (owner_q == IDW'(i));
      rsp_valid[i]  = inflight_v_q && (inflight_id_q == IDW'(i));
    end
  end

  // While locked only the owner competes; otherwise everybody does.
  assign pick_req = (state_q == LOCK) ? (req_valid & owner_mask) : req_valid;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_picker (
    .req        (pick_req),
    .ptr        (rr_ptr_q),
    .gnt_onehot (pick_onehot),
    .gnt_id     (gnt_id),
    .any        (pick_any)
  );

  // Grants are suppressed while reset is held so nothing issues into a
  // block whose state is being cleared.
  assign gnt       = rst_n ? pick_onehot : '0;
  assign req_ready = gnt;
  assign issue     = pick_any && rst_n;
  assign lock_sel  = |(req_lock & gnt);
  assign idle_inc  = idle_cnt_q + 8'd1;

  // Operand/control mux onto the ALU; NOP control when nobody is granted.
  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = '0;
    for (int i = 0; i < N_REQ; i++) begin
      alu_a       = alu_a       | (req_a[8*i +: 8]    & {8{gnt[i]}});
      alu_b       = alu_b       | (req_b[8*i +: 8]    & {8{gnt[i]}});
      alu_control = alu_control | (req_ctrl[4*i +: 4] & {4{gnt[i]}});
    end
    if (!issue) alu_control = ALU_CTRL_IDLE;
  end

  // Arbitration state, pointer, lock owner and idle timeout.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    idle_cnt_d    = idle_cnt_q;
    inflight_v_d  = issue;
    inflight_id_d = gnt_id;
    case (state_q)
      ARB: begin
        if (issue) begin
          rr_ptr_d = next_id(gnt_id);
          if (lock_sel) begin
            state_d    = LOCK;
            owner_d    = gnt_id;
            idle_cnt_d = '0;
          end
        end
      end
      LOCK: begin
        if (issue) begin
          idle_cnt_d = '0;
          if (!lock_sel) begin
            state_d  = ARB;
            rr_ptr_d = next_id(owner_q);
          end
        end else if (idle_inc == 8'(LOCK_MAX)) begin
          // Owner went quiet for too long: release without issuing.
          state_d    = ARB;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_inc;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // State registers; reset drops any lock and any in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARB;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      idle_cnt_q    <= '0;
      inflight_v_q  <= 1'b0;
      inflight_id_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      idle_cnt_q    <= idle_cnt_d;
      inflight_v_q  <= inflight_v_d;
      inflight_id_q <= inflight_id_d;
    end
  end

  assign rsp_id       = inflight_id_q;
  assign rsp_result   = alu_result;
  assign rsp_zero     = alu_zero;
  assign rsp_overflow = alu_overflow;

endmodule
